// File: rtl/noc_flit_vc_fifo.sv
// Multi-VC flit FIFO with a packet-locking round-robin output arbiter.
// Optional macro NOC_FLIT_VC_FIFO_OCCUPANCY_EN adds the per-channel o_count port.
module noc_flit_vc_fifo #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 8,
    parameter int CHANNELS = 4,
    localparam int VCW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_clear,
    input  logic [CHANNELS-1:0]       i_valid,
    output logic [CHANNELS-1:0]       o_ready,
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [CHANNELS-1:0]       i_last,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [WIDTH-1:0]          o_data,
    output logic                      o_last,
    output logic [VCW-1:0]            o_vc,
    output logic [CHANNELS-1:0]       o_empty,
    output logic [CHANNELS-1:0]       o_full
`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
    ,
    output logic [CHANNELS*CW-1:0]    o_count
`endif
);

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    arb_state_e                    state_q, state_d;
    logic [VCW-1:0]                rr_q, rr_d;
    logic [VCW-1:0]                sel_vc_q, sel_vc_d;
    logic                          hold_q, hold_d;
    logic [VCW-1:0]                rr_pick, cand, cur_vc;
    logic                          found;
    logic                          pop_any;
    logic [CHANNELS-1:0]           push, pop;
    logic [CHANNELS-1:0][PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CHANNELS-1:0][CW-1:0]   count_q, count_d;
    logic [CHANNELS-1:0][WIDTH:0]  head_flit;
    logic [WIDTH:0]                head;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [WIDTH:0] mem [DEPTH];

        assign o_empty[gi] = (count_q[gi] == '0);
        assign o_full[gi]  = (count_q[gi] == CW'(DEPTH));
        assign o_ready[gi] = !o_full[gi];
        assign push[gi]    = i_valid[gi] && o_ready[gi];
        assign pop[gi]     = pop_any && (cur_vc == VCW'(gi));

        always_ff @(posedge clk) begin
            if (push[gi] && !i_clear) begin
                mem[wr_ptr_q[gi]] <= {i_last[gi], i_data[gi*WIDTH +: WIDTH]};
            end
        end
        assign head_flit[gi] = mem[rd_ptr_q[gi]];

`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
        assign o_count[gi*CW +: CW] = count_q[gi];
`endif
    end

    // Full/empty come from the count; pointers wrap naturally at a power-of-two DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
                if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
                count_d[c] = count_q[c] + CW'(push[c]) - CW'(pop[c]);
            end
        end
    end

    always_comb begin
        rr_pick = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = VCW'((int'(rr_q) + i) % CHANNELS);
            if (!found && !o_empty[cand]) begin
                found   = 1'b1;
                rr_pick = cand;
            end
        end
    end

    // A presented-but-stalled flit freezes the selection so later pushes cannot steal it.
    assign cur_vc  = (state_q == ARB_LOCKED || hold_q) ? sel_vc_q : rr_pick;
    assign head    = head_flit[cur_vc];
    assign o_valid = !o_empty[cur_vc];
    assign pop_any = o_valid && i_ready;
    assign o_vc    = cur_vc;
    assign o_data  = o_valid ? head[WIDTH-1:0] : '0;
    assign o_last  = o_valid && head[WIDTH];

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        sel_vc_d = sel_vc_q;
        hold_d   = 1'b0;
        if (i_clear) begin
            state_d  = ARB_IDLE;
            rr_d     = VCW'(CHANNELS - 1);
            sel_vc_d = '0;
        end else if (pop_any) begin
            rr_d     = cur_vc;
            sel_vc_d = cur_vc;
            state_d  = head[WIDTH] ? ARB_IDLE : ARB_LOCKED;
        end else if (o_valid) begin
            hold_d   = 1'b1;
            sel_vc_d = cur_vc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            rr_q     <= VCW'(CHANNELS - 1);
            sel_vc_q <= '0;
            hold_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            sel_vc_q <= sel_vc_d;
            hold_q   <= hold_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_noc_flit_vc_fifo.sv
// Scoreboard bench for noc_flit_vc_fifo: stimulus queues expected flits, a monitor checks every pop.
module tb_noc_flit_vc_fifo;
    localparam int WIDTH    = 64;
    localparam int DEPTH    = 8;
    localparam int CHANNELS = 4;
    localparam int VCW      = 2;
    localparam int CW       = 4;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      i_clear;
    logic [CHANNELS-1:0]       i_valid;
    logic [CHANNELS-1:0]       o_ready;
    logic [CHANNELS*WIDTH-1:0] i_data;
    logic [CHANNELS-1:0]       i_last;
    logic                      o_valid;
    logic                      i_ready;
    logic [WIDTH-1:0]          o_data;
    logic                      o_last;
    logic [VCW-1:0]            o_vc;
    logic [CHANNELS-1:0]       o_empty;
    logic [CHANNELS-1:0]       o_full;
`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
    logic [CHANNELS*CW-1:0]    o_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [VCW+WIDTH:0] exp_q[$];

    noc_flit_vc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
        .o_vc(o_vc), .o_empty(o_empty), .o_full(o_full)
`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
        , .o_count(o_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ch(input int c, input logic [WIDTH-1:0] d, input logic l);
        i_valid[c] = 1'b1;
        i_data[c*WIDTH +: WIDTH] = d;
        i_last[c] = l;
    endtask

    task automatic exp_flit(input int c, input logic l, input logic [WIDTH-1:0] d);
        exp_q.push_back({2'(c), l, d});
    endtask

    task automatic do_reset();
        i_valid = '0;
        i_clear = 1'b0;
        i_ready = 1'b0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string name);
        int budget;
        i_valid = '0;
        i_ready = 1'b1;
        budget  = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            tick();
            budget++;
        end
        check({name, "_pending"}, 128'(exp_q.size()), 128'd0);
        tick();
        tick();
        check({name, "_idle"}, 128'(o_valid), 128'd0);
        i_ready = 1'b0;
    endtask

    // Monitor: every handshake pops one expected flit.
    initial begin
        logic [VCW+WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && o_valid && i_ready) begin
                n_checks++;
                $display("pop vc=%0d last=%0b data=%h", o_vc, o_last, o_data);
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_flit: got vc=%0d last=%0b data=%h, required no output",
                             o_vc, o_last, o_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_vc, o_last, o_data} !== e) begin
                        n_fail++;
                        $display("FAIL pop_flit: got vc=%0d last=%0b data=%h, required vc=%0d last=%0b data=%h",
                                 o_vc, o_last, o_data, e[VCW+WIDTH:WIDTH+1], e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        i_clear = 1'b0;
        i_valid = '0;
        i_data  = '0;
        i_last  = '0;
        i_ready = 1'b0;
        tick();
        tick();
        // Reset state
        check("rst_valid", 128'(o_valid), 128'd0);
        check("rst_empty", 128'(o_empty), 128'hF);
        check("rst_full",  128'(o_full),  128'h0);
        check("rst_ready", 128'(o_ready), 128'hF);
        check("rst_vc",    128'(o_vc),    128'd0);
        check("rst_last",  128'(o_last),  128'd0);
        rst_n = 1'b1;
        tick();

        // Fill ch1 to DEPTH with the output stalled, then try a refused 9th push
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            i_valid = '0;
            push_ch(1, 64'h1100 + 64'(k), k == DEPTH - 1);
            exp_flit(1, k == DEPTH - 1, 64'h1100 + 64'(k));
            tick();
            check("fill_full1", 128'(o_full[1]), 128'(k == DEPTH - 1));
        end
        check("full_ready1", 128'(o_ready[1]), 128'd0);
        check("full_vc", 128'(o_vc), 128'd1);
        i_valid = '0;
        push_ch(1, 64'hDEAD, 1'b1);
        tick();
        i_valid = '0;
        check("refused_full1", 128'(o_full[1]), 128'd1);
        drain("full");

        // Three-flit packet on ch0 and single flit on ch2 queued together
        do_reset();
        i_valid = '0;
        push_ch(0, 64'hA0, 1'b0);
        push_ch(2, 64'hC0, 1'b1);
        tick();
        i_valid = '0;
        push_ch(0, 64'hA1, 1'b0);
        tick();
        i_valid = '0;
        push_ch(0, 64'hA2, 1'b1);
        tick();
        exp_flit(0, 1'b0, 64'hA0);
        exp_flit(0, 1'b0, 64'hA1);
        exp_flit(0, 1'b1, 64'hA2);
        exp_flit(2, 1'b1, 64'hC0);
        i_valid = '0;
        check("pkt_first_vc", 128'(o_vc), 128'd0);
        drain("pkt");

        // Single-flit packets on all channels rotate 0,1,2,3,0,...
        do_reset();
        for (int r = 0; r < 2; r++) begin
            i_valid = '0;
            for (int c = 0; c < CHANNELS; c++) push_ch(c, 64'h40 + 64'(16*r + c), 1'b1);
            tick();
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < CHANNELS; c++) exp_flit(c, 1'b1, 64'h40 + 64'(16*r + c));
        drain("rr");

        // Stalled ch3 flit must stay presented while ch0 fills
        do_reset();
        i_valid = '0;
        push_ch(3, 64'hD3, 1'b1);
        exp_flit(3, 1'b1, 64'hD3);
        tick();
        for (int k = 0; k < 5; k++) begin
            i_valid = '0;
            push_ch(0, 64'hE0 + 64'(k), 1'b1);
            exp_flit(0, 1'b1, 64'hE0 + 64'(k));
            tick();
            check("stall_vc", 128'(o_vc), 128'd3);
            check("stall_data", 128'(o_data), 128'hD3);
        end
        drain("stall");

        // Clear mid-packet together with a push to ch1
        do_reset();
        i_ready = 1'b1;
        i_valid = '0;
        push_ch(0, 64'hF0, 1'b0);
        exp_flit(0, 1'b0, 64'hF0);
        tick();
        i_valid = '0;
        push_ch(0, 64'hF1, 1'b0);
        tick();
        i_ready = 1'b0;
        i_valid = '0;
        push_ch(1, 64'hF9, 1'b1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_valid = '0;
        check("clr_valid", 128'(o_valid), 128'd0);
        check("clr_empty", 128'(o_empty), 128'hF);
        check("clr_ready", 128'(o_ready), 128'hF);
        push_ch(2, 64'hF2, 1'b1);
        exp_flit(2, 1'b1, 64'hF2);
        tick();
        drain("clr");

        // Push and pop together on ch2, then asynchronous reset mid-cycle
        do_reset();
        for (int k = 0; k < 5; k++) begin
            i_valid = '0;
            push_ch(2, 64'h2000 + 64'(k), 1'b1);
            tick();
        end
`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
        check("cnt_five", 128'(o_count[2*CW +: CW]), 128'd5);
`endif
        i_valid = '0;
        push_ch(2, 64'h2005, 1'b1);
        exp_flit(2, 1'b1, 64'h2000);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        i_valid = '0;
`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
        check("cnt_pushpop", 128'(o_count[2*CW +: CW]), 128'd5);
`endif
        check("pushpop_empty2", 128'(o_empty[2]), 128'd0);
        check("pushpop_data", 128'(o_data), 128'h2001);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_empty", 128'(o_empty), 128'hF);
        check("arst_valid", 128'(o_valid), 128'd0);
`ifdef NOC_FLIT_VC_FIFO_OCCUPANCY_EN
        check("arst_count", 128'(o_count), 128'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_valid", 128'(o_valid), 128'd0);
        check("post_rst_pending", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
